data_memory_ctrl: RTL and testbench

- Parametrised successor to the single-port data memory; the load/store unit of the pipeline talks to it.
- Byte-addressed, word-organised RAM with RISC-V funct3 access sizes (byte, half, word; signed and unsigned loads).
- Single-entry request/response valid-ready handshake with a registered response.
- Detects misaligned, out-of-range and illegal-size accesses and reports them as error responses instead of corrupting memory.

---
 rtl/data_memory_ctrl_if.sv | 26 ++
 rtl/data_memory_ctrl.sv | 126 ++++++++++++
 tb/tb_data_memory_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the load/store unit (master) and the data memory (slave).
interface data_memory_ctrl_if #(
    parameter int WIDTH_DATA = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_write_i;
    logic [2:0]            req_size_i;
    logic [WIDTH_DATA-1:0] addr_i;
    logic [WIDTH_DATA-1:0] wr_data_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [WIDTH_DATA-1:0] rd_data_o;
    logic                  rsp_error_o;
    logic [1:0]            rsp_err_code_o;

    modport master (
        output req_valid_i, req_write_i, req_size_i, addr_i, wr_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rd_data_o, rsp_error_o, rsp_err_code_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_size_i, addr_i, wr_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rd_data_o, rsp_error_o, rsp_err_code_o
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed, word-organised data RAM with funct3 access sizes, error checking and a
// single registered response slot that supports one access per cycle.
module data_memory_ctrl #(
    parameter int          WIDTH_DATA  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clock_i,
    input  logic              reset_i,
    data_memory_ctrl_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_MISALGN = 2'b01;
    localparam logic [1:0] CODE_RANGE   = 2'b10;
    localparam logic [1:0] CODE_SIZE    = 2'b11;

    logic [WIDTH_DATA-1:0] mem [DEPTH_WORDS];

    logic [WIDTH_DATA-1:0] offset;
    logic [AW-1:0]         idx;
    logic [1:0]            lane;
    logic [1:0]            code;
    logic                  illegal_size;
    logic                  misaligned;
    logic                  req_ready;
    logic                  accept;
    logic                  do_write;
    logic [3:0]            byte_en;
    logic [WIDTH_DATA-1:0] wr_lanes;

    logic                  vld_p1;
    logic [WIDTH_DATA-1:0] data_p1;
    logic                  err_p1;
    logic [1:0]            code_p1;

    // Select the addressed lane(s) of a word and sign- or zero-extend per funct3.
    function automatic logic [WIDTH_DATA-1:0] load_extend(
        input logic [WIDTH_DATA-1:0] word,
        input logic [2:0]            size,
        input logic [1:0]            lane_sel
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lane_sel, 3'b000} +: 8];
        h = lane_sel[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  return WIDTH_DATA'(b);
            3'b100:  return {24'b0, b};
            3'b001:  return WIDTH_DATA'(h);
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    // Addresses below BASE_ADDR wrap to huge offsets and so fail the range check.
    assign offset = bus.addr_i - BASE_ADDR;
    assign idx    = offset[AW+1:2];
    assign lane   = bus.addr_i[1:0];

    assign illegal_size = (bus.req_size_i == 3'b011) || (bus.req_size_i[2:1] == 2'b11) ||
                          (bus.req_write_i && bus.req_size_i[2]);
    assign misaligned   = (bus.req_size_i[1:0] == 2'b01 && lane[0]) ||
                          (bus.req_size_i[1:0] == 2'b10 && lane != 2'b00);

    always_comb begin
        code = CODE_OK;
        if (illegal_size)          code = CODE_SIZE;
        else if (offset >= SPAN)   code = CODE_RANGE;
        else if (misaligned)       code = CODE_MISALGN;
    end

    assign req_ready = !vld_p1 || bus.rsp_ready_i;
    assign accept    = bus.req_valid_i && req_ready && !reset_i;
    assign do_write  = accept && bus.req_write_i && (code == CODE_OK);

    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = bus.wr_data_i;
        case (bus.req_size_i[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{bus.wr_data_i[7:0]}};
            end
            2'b01: begin
                byte_en  = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{bus.wr_data_i[15:0]}};
            end
            default: byte_en = 4'b1111;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    // Stage p1: response register, reloaded on accept and held under backpressure.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            err_p1  <= 1'b0;
            code_p1 <= CODE_OK;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            err_p1  <= (code != CODE_OK);
            code_p1 <= code;
            data_p1 <= (code == CODE_OK && !bus.req_write_i) ?
                       load_extend(mem[idx], bus.req_size_i, lane) : '0;
        end else if (bus.rsp_ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.req_ready_o    = req_ready;
    assign bus.rsp_valid_o    = vld_p1;
    assign bus.rd_data_o      = data_p1;
    assign bus.rsp_error_o    = err_p1;
    assign bus.rsp_err_code_o = code_p1;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed plan items plus randomized traffic
// scored against a byte-array reference model.
module tb_data_memory_ctrl;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] model_mem [0:DEPTH*4-1];

    data_memory_ctrl_if #(.WIDTH_DATA(32)) bus ();

    data_memory_ctrl #(.WIDTH_DATA(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock_i(clk),
        .reset_i(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: memory as a flat little-endian byte array, rules applied directly.
    task automatic model_access(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] data,
                                output logic [1:0] code);
        logic [31:0] off;
        int          nb;
        logic [31:0] val;
        off  = a - BASE;
        nb   = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        data = 32'd0;
        if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7 || (wr && sz >= 3'd4)) code = 2'd3;
        else if (off >= 32'(DEPTH * 4))                                   code = 2'd2;
        else if ((off % 32'(nb)) != 0)                                    code = 2'd1;
        else                                                              code = 2'd0;
        if (code == 2'd0) begin
            if (wr) begin
                for (int k = 0; k < nb; k++) model_mem[int'(off) + k] = wd[8*k +: 8];
            end else begin
                val = 32'd0;
                for (int k = 0; k < nb; k++) val = val | (32'(model_mem[int'(off) + k]) << (8*k));
                if (!sz[2] && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8*nb)) - 32'd1);
                data = val;
            end
        end
    endtask

    task automatic send(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic acc, output logic vld,
                        output logic err, output logic [1:0] code, output logic [31:0] data);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = wr;
        bus.req_size_i  = sz;
        bus.addr_i      = a;
        bus.wr_data_i   = wd;
        bus.rsp_ready_i = 1'b1;
        #1 acc = bus.req_ready_o;
        @(posedge clk);
        @(negedge clk);
        vld  = bus.rsp_valid_o;
        err  = bus.rsp_error_o;
        code = bus.rsp_err_code_o;
        data = bus.rd_data_o;
        bus.req_valid_i = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_size_i  = 3'd0;
        bus.addr_i      = 32'd0;
        bus.wr_data_i   = 32'd0;
        bus.rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid_o); end
        checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data_o); end
        checks++; if (bus.rsp_error_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got %b want 0", bus.rsp_error_o); end
        checks++; if (bus.rsp_err_code_o !== 2'b00) begin errors++; $display("FAIL reset_err_code got %b want 00", bus.rsp_err_code_o); end
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready_o); end
        rst = 1'b0;
    endtask

    task automatic test_init();
        logic acc, vld, err;
        logic [1:0] code, mc;
        logic [31:0] data, md;
        for (int w = 0; w < 64; w++) begin
            send(1'b1, 3'd2, 32'(w*4), 32'd0, acc, vld, err, code, data);
            model_access(1'b1, 3'd2, 32'(w*4), 32'd0, md, mc);
            checks++;
            if ({acc, vld, err, code, data} !== {1'b1, 1'b1, 1'b0, 2'b00, 32'd0}) begin
                errors++;
                $display("FAIL init_store[%0d] got acc=%b vld=%b err=%b code=%b data=%h want 1 1 0 00 0",
                         w, acc, vld, err, code, data);
            end
        end
    endtask

    typedef struct packed {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] d;
        logic [1:0]  c;
    } vec_t;

    task automatic test_directed();
        vec_t vecs [22];
        logic acc, vld, err;
        logic [1:0] code, mc;
        logic [31:0] data, md;
        vecs = '{
            '{1'b1, 3'd2, 32'h10,        32'h8765_4321, 32'h0000_0000, 2'd0},
            '{1'b0, 3'd2, 32'h10,        32'h0,         32'h8765_4321, 2'd0},
            '{1'b1, 3'd0, 32'h21,        32'h1234_56F0, 32'h0000_0000, 2'd0},
            '{1'b0, 3'd0, 32'h21,        32'h0,         32'hFFFF_FFF0, 2'd0},
            '{1'b0, 3'd4, 32'h21,        32'h0,         32'h0000_00F0, 2'd0},
            '{1'b0, 3'd2, 32'h20,        32'h0,         32'h0000_F000, 2'd0},
            '{1'b1, 3'd1, 32'h32,        32'hABCD_8001, 32'h0000_0000, 2'd0},
            '{1'b0, 3'd1, 32'h32,        32'h0,         32'hFFFF_8001, 2'd0},
            '{1'b0, 3'd5, 32'h32,        32'h0,         32'h0000_8001, 2'd0},
            '{1'b0, 3'd2, 32'h30,        32'h0,         32'h8001_0000, 2'd0},
            '{1'b0, 3'd2, 32'h11,        32'h0,         32'h0,         2'd1},
            '{1'b1, 3'd1, 32'h13,        32'hFFFF_FFFF, 32'h0,         2'd1},
            '{1'b0, 3'd2, 32'h10,        32'h0,         32'h8765_4321, 2'd0},
            '{1'b0, 3'd2, 32'd4096,      32'h0,         32'h0,         2'd2},
            '{1'b0, 3'd3, 32'h10,        32'h0,         32'h0,         2'd3},
            '{1'b1, 3'd4, 32'h10,        32'hFFFF_FFFF, 32'h0,         2'd3},
            '{1'b0, 3'd2, 32'h10,        32'h0,         32'h8765_4321, 2'd0},
            '{1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0,         32'h0,         2'd2},
            '{1'b0, 3'd7, 32'h1001,      32'h0,         32'h0,         2'd3},
            '{1'b0, 3'd1, 32'h1001,      32'h0,         32'h0,         2'd2},
            '{1'b0, 3'd0, 32'h13,        32'h0,         32'hFFFF_FF87, 2'd0},
            '{1'b0, 3'd5, 32'h12,        32'h0,         32'h0000_8765, 2'd0}
        };
        for (int i = 0; i < 22; i++) begin
            send(vecs[i].wr, vecs[i].sz, vecs[i].a, vecs[i].wd, acc, vld, err, code, data);
            model_access(vecs[i].wr, vecs[i].sz, vecs[i].a, vecs[i].wd, md, mc);
            checks++;
            if ({acc, vld, err, code, data} !== {1'b1, 1'b1, vecs[i].c != 2'd0, vecs[i].c, vecs[i].d}) begin
                errors++;
                $display("FAIL directed[%0d] got acc=%b vld=%b err=%b code=%b data=%h want code=%b data=%h",
                         i, acc, vld, err, code, data, vecs[i].c, vecs[i].d);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q [3];
        logic [2:0]  sz_q  [3];
        logic [31:0] a_q   [3];
        exp_q = '{32'h8001_0000, 32'hFFFF_FFF0, 32'h0000_8001};
        sz_q  = '{3'd2, 3'd0, 3'd5};
        a_q   = '{32'h30, 32'h21, 32'h32};
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b0;
        bus.req_size_i  = 3'd2;
        bus.addr_i      = 32'h10;
        bus.rsp_ready_i = 1'b0;
        #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %b want 1", bus.req_ready_o); end
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.addr_i = a_q[0];
            #1;
            checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low[%0d] got %b want 0", c, bus.req_ready_o); end
            checks++;
            if ({bus.rsp_valid_o, bus.rsp_error_o, bus.rsp_err_code_o, bus.rd_data_o} !== {1'b1, 1'b0, 2'b00, 32'h8765_4321}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got vld=%b err=%b code=%b data=%h want 1 0 00 87654321", c,
                         bus.rsp_valid_o, bus.rsp_error_o, bus.rsp_err_code_o, bus.rd_data_o);
            end
        end
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bus.req_size_i = sz_q[j];
            bus.addr_i     = a_q[j];
            #1;
            checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready[%0d] got %b want 1", j, bus.req_ready_o); end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid_o, bus.rsp_error_o, bus.rd_data_o} !== {1'b1, 1'b0, exp_q[j]}) begin
                errors++;
                $display("FAIL bp_stream[%0d] got vld=%b err=%b data=%h want 1 0 %h", j,
                         bus.rsp_valid_o, bus.rsp_error_o, bus.rd_data_o, exp_q[j]);
            end
        end
        bus.req_valid_i = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic acc, vld, err;
        logic [1:0] code;
        logic [31:0] data;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b0;
        bus.req_size_i  = 3'd2;
        bus.addr_i      = 32'h10;
        bus.rsp_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b want 1", bus.rsp_valid_o); end
        rst = 1'b1;
        bus.req_write_i = 1'b1;
        bus.addr_i      = 32'h40;
        bus.wr_data_i   = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_discard got %b want 0", bus.rsp_valid_o); end
        rst = 1'b0;
        bus.req_valid_i = 1'b0;
        send(1'b0, 3'd2, 32'h40, 32'd0, acc, vld, err, code, data);
        checks++;
        if ({vld, err, data} !== {1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL rstmid_no_write got vld=%b err=%b data=%h want 1 0 00000000", vld, err, data);
        end
    endtask

    task automatic test_back_to_back();
        logic        have_exp;
        logic        accept;
        logic [31:0] exp_data;
        logic [1:0]  exp_code;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a, wd;
        have_exp = 1'b0;
        exp_data = 32'd0;
        exp_code = 2'd0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (have_exp) begin
                if ({bus.rsp_valid_o, bus.rsp_error_o, bus.rsp_err_code_o, bus.rd_data_o} !==
                    {1'b1, exp_code != 2'd0, exp_code, exp_data}) begin
                    errors++;
                    $display("FAIL random_rsp[%0d] got vld=%b err=%b code=%b data=%h want 1 code=%b data=%h", i,
                             bus.rsp_valid_o, bus.rsp_error_o, bus.rsp_err_code_o, bus.rd_data_o, exp_code, exp_data);
                end
            end else if (bus.rsp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL random_idle[%0d] got vld=%b want 0", i, bus.rsp_valid_o);
            end
            wr = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0000_1000) : 32'($urandom_range(0, 255));
            wd = $urandom;
            bus.req_valid_i = ($urandom_range(0, 3) != 0);
            bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
            bus.req_write_i = wr;
            bus.req_size_i  = sz;
            bus.addr_i      = a;
            bus.wr_data_i   = wd;
            #1;
            checks++;
            if (bus.req_ready_o !== (!have_exp || bus.rsp_ready_i)) begin
                errors++;
                $display("FAIL random_ready[%0d] got %b want %b", i, bus.req_ready_o, !have_exp || bus.rsp_ready_i);
            end
            accept = bus.req_valid_i && (!have_exp || bus.rsp_ready_i);
            if (accept) begin
                model_access(wr, sz, a, wd, exp_data, exp_code);
                have_exp = 1'b1;
            end else if (bus.rsp_ready_i) begin
                have_exp = 1'b0;
            end
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
